regfile_sb: RTL and testbench

//   Parametrised general-purpose register file: 2 async read ports, 1 sync write port,

---
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// General-purpose register file with two async read ports, one write port, a PC port on the
// top register and a per-register busy scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              wr_n,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rsv_n,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              pc_wr_n,
   input  logic [WIDTH-1:0]  pc_in,
   output logic [WIDTH-1:0]  pc_out
);

   localparam int NREGS  = 1 << ADDR_W;
   localparam int PC_IDX = NREGS - 1;

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [NREGS-1:0] r_busy;

   logic [NREGS-1:0] w_wr_sel;
   logic [NREGS-1:0] w_rsv_sel;
   logic             w_pc_sel;

   assign w_wr_sel  = (NREGS'(1) << wr_addr) & {NREGS{~wr_n}};
   assign w_rsv_sel = (NREGS'(1) << rsv_addr) & {NREGS{~rsv_n}};
   assign w_pc_sel  = ~pc_wr_n;

   // Writeback data takes priority over the PC strobe so a branch writeback to the PC lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_busy <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_wr_sel[i])
               r_regs[i] <= wr_data;
            else if (w_pc_sel && (i == PC_IDX))
               r_regs[i] <= pc_in;
         end
         // Reserve beats release on the same register: a new producer is already in flight.
         r_busy <= (r_busy & ~w_wr_sel) | w_rsv_sel;
      end
   end

   assign pc_out = r_regs[PC_IDX];

`ifdef REGFILE_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   assign w_byp_a   = ~wr_n && (rd_addr_a == wr_addr);
   assign w_byp_b   = ~wr_n && (rd_addr_b == wr_addr);
   assign rd_data_a = w_byp_a ? wr_data : r_regs[rd_addr_a];
   assign rd_data_b = w_byp_b ? wr_data : r_regs[rd_addr_b];
   // A forwarded write clears busy unless the same register is being re-reserved this cycle.
   assign busy_a    = w_byp_a ? w_rsv_sel[rd_addr_a] : r_busy[rd_addr_a];
   assign busy_b    = w_byp_b ? w_rsv_sel[rd_addr_b] : r_busy[rd_addr_b];
`else
   assign rd_data_a = r_regs[rd_addr_a];
   assign rd_data_b = r_regs[rd_addr_b];
   assign busy_a    = r_busy[rd_addr_a];
   assign busy_b    = r_busy[rd_addr_b];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand-written corner sequences and random
// traffic checked against an array-based reference model.
module tb_regfile_sb;

   localparam int WIDTH  = 16;
   localparam int ADDR_W = 3;
   localparam int NREGS  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
   logic [WIDTH-1:0]  rd_data_a, rd_data_b, wr_data, pc_in, pc_out;
   logic              busy_a, busy_b, wr_n, rsv_n, pc_wr_n;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] m_reg  [NREGS];
   logic             m_busy [NREGS];

   regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .busy_a(busy_a), .busy_b(busy_b),
      .wr_n(wr_n), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_n(rsv_n), .rsv_addr(rsv_addr),
      .pc_wr_n(pc_wr_n), .pc_in(pc_in), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             wr_n;
      logic [2:0]       wr_addr;
      logic [15:0]      wr_data;
      logic             rsv_n;
      logic [2:0]       rsv_addr;
      logic             pc_wr_n;
      logic [15:0]      pc_in;
      logic [2:0]       rd_a;
      logic [2:0]       rd_b;
      logic [15:0]      exp_a;
      logic [15:0]      exp_b;
      logic             exp_busy_a;
      logic             exp_busy_b;
      logic [15:0]      exp_pc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      reset   = 1'b0;
      wr_n    = 1'b1; wr_addr  = '0; wr_data = '0;
      rsv_n   = 1'b1; rsv_addr = '0;
      pc_wr_n = 1'b1; pc_in    = '0;
   endtask

   // Reference model: apply the edge rules in order; later statements have priority.
   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      end else begin
         if (!pc_wr_n) m_reg[NREGS-1] = pc_in;
         if (!wr_n) begin m_reg[wr_addr] = wr_data; m_busy[wr_addr] = 1'b0; end
         if (!rsv_n) m_busy[rsv_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] exp_rd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
      if (!wr_n && a == wr_addr) return wr_data;
`endif
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
      if (!wr_n && a == wr_addr) return (!rsv_n && rsv_addr == a);
`endif
      return m_busy[a];
   endfunction

   task automatic chk_model(input string tag);
      chk({tag, "_rd_a"}, rd_data_a, exp_rd(rd_addr_a));
      chk({tag, "_rd_b"}, rd_data_b, exp_rd(rd_addr_b));
      chk({tag, "_busy_a"}, WIDTH'(busy_a), WIDTH'(exp_busy(rd_addr_a)));
      chk({tag, "_busy_b"}, WIDTH'(busy_b), WIDTH'(exp_busy(rd_addr_b)));
      chk({tag, "_pc"}, pc_out, m_reg[NREGS-1]);
   endtask

   initial begin
      //           wr_n a  data      rsv_n a  pc_n pc_in     rda rdb exp_a     exp_b    ba bb exp_pc
      vecs[0] = '{1'b0, 3, 16'hA5A5, 1'b1, 0, 1'b1, 16'h0000, 3, 2, 16'hA5A5, 16'h0000, 0, 0, 16'h0000};
      vecs[1] = '{1'b1, 0, 16'h0000, 1'b0, 5, 1'b1, 16'h0000, 5, 4, 16'h0000, 16'h0000, 1, 0, 16'h0000};
      vecs[2] = '{1'b0, 5, 16'h5555, 1'b1, 0, 1'b1, 16'h0000, 5, 3, 16'h5555, 16'hA5A5, 0, 0, 16'h0000};
      vecs[3] = '{1'b0, 2, 16'h2222, 1'b0, 2, 1'b1, 16'h0000, 2, 4, 16'h2222, 16'h0000, 1, 0, 16'h0000};
      vecs[4] = '{1'b0, 7, 16'h0200, 1'b1, 0, 1'b0, 16'h0010, 7, 2, 16'h0200, 16'h2222, 0, 1, 16'h0200};
      vecs[5] = '{1'b1, 0, 16'h0000, 1'b1, 0, 1'b0, 16'h0040, 7, 5, 16'h0040, 16'h5555, 0, 0, 16'h0040};
      vecs[6] = '{1'b1, 0, 16'h0000, 1'b0, 7, 1'b0, 16'h0044, 7, 3, 16'h0044, 16'hA5A5, 1, 0, 16'h0044};
      vecs[7] = '{1'b0, 2, 16'h0000, 1'b0, 4, 1'b1, 16'h0000, 4, 2, 16'h0000, 16'h0000, 1, 0, 16'h0044};
      vecs[8] = '{1'b1, 0, 16'h0000, 1'b0, 4, 1'b0, 16'h0050, 4, 6, 16'h0000, 16'h0000, 1, 0, 16'h0050};

      set_idle();
      rd_addr_a = '0; rd_addr_b = 3'd7;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_rd_a", rd_data_a, 16'h0000);
      chk("reset_rd_b", rd_data_b, 16'h0000);
      chk("reset_busy", {14'b0, busy_a, busy_b}, 16'h0000);
      chk("reset_pc", pc_out, 16'h0000);

      for (int v = 0; v < 9; v++) begin
         wr_n = vecs[v].wr_n; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
         rsv_n = vecs[v].rsv_n; rsv_addr = vecs[v].rsv_addr;
         pc_wr_n = vecs[v].pc_wr_n; pc_in = vecs[v].pc_in;
         tick();
         set_idle();
         rd_addr_a = vecs[v].rd_a; rd_addr_b = vecs[v].rd_b;
         #1;
         chk($sformatf("vec%0d_rd_a", v), rd_data_a, vecs[v].exp_a);
         chk($sformatf("vec%0d_rd_b", v), rd_data_b, vecs[v].exp_b);
         chk($sformatf("vec%0d_busy_a", v), WIDTH'(busy_a), WIDTH'(vecs[v].exp_busy_a));
         chk($sformatf("vec%0d_busy_b", v), WIDTH'(busy_b), WIDTH'(vecs[v].exp_busy_b));
         chk($sformatf("vec%0d_pc", v), pc_out, vecs[v].exp_pc);
      end

      // Same-cycle read of a register being written: forwarded or old value.
      wr_n = 1'b0; wr_addr = 3'd1; wr_data = 16'h1111;
      tick();
      wr_data = 16'h1234; rd_addr_b = 3'd1;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("same_cycle_rd_b", rd_data_b, 16'h1234);
`else
      chk("same_cycle_rd_b", rd_data_b, 16'h1111);
`endif
      tick();
      set_idle();
      #1;
      chk("after_write_rd_b", rd_data_b, 16'h1234);

      // Reset beats a simultaneous write.
      reset = 1'b1; wr_n = 1'b0; wr_addr = 3'd1; wr_data = 16'hBEEF;
      tick();
      set_idle();
      #1;
      chk("reset_beats_write", rd_data_b, 16'h0000);

      // Random traffic against the model, checking combinational reads before each edge.
      for (int c = 0; c < 400; c++) begin
         reset    = ($urandom_range(0, 31) == 0);
         wr_n     = $urandom_range(0, 1);
         wr_addr  = ADDR_W'($urandom_range(0, NREGS-1));
         wr_data  = WIDTH'($urandom);
         rsv_n    = $urandom_range(0, 1);
         rsv_addr = ADDR_W'($urandom_range(0, NREGS-1));
         pc_wr_n  = $urandom_range(0, 1);
         pc_in    = WIDTH'($urandom);
         rd_addr_a = ADDR_W'($urandom_range(0, NREGS-1));
         rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, NREGS-1));
         #1;
         chk_model($sformatf("rand%0d", c));
         tick();
      end

      // Reset after random writes clears every register and busy bit.
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         rd_addr_a = ADDR_W'(i); rd_addr_b = ADDR_W'(NREGS - 1 - i);
         #1;
         chk($sformatf("post_reset_rd_a%0d", i), rd_data_a, 16'h0000);
         chk($sformatf("post_reset_busy_a%0d", i), WIDTH'(busy_a), 16'h0000);
         chk($sformatf("post_reset_busy_b%0d", i), WIDTH'(busy_b), 16'h0000);
      end
      chk("post_reset_pc", pc_out, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
